lcg_stream_checker: RTL



---
 rtl/lcg_chk_pkg.sv | 22 ++
 rtl/lcg_step.sv | 14 +
 rtl/lcg_stream_checker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lcg_chk_pkg.sv
// Shared types and constants for the LCG stream checker.
// The default build has no MISR. Defining LCG_CHK_MISR_EN adds it.
package lcg_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [31:0] LCG_MULT  = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC   = 32'h00003039;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] lcg_next(input logic [31:0] x,
                                           input logic [31:0] mult = LCG_MULT,
                                           input logic [31:0] inc  = LCG_INC);
    return x * mult + inc;
  endfunction

endpackage

// File: rtl/lcg_step.sv
// Combinational LCG next-state calculator, x' = x*MULT + INC (mod 2^32).
module lcg_step
  import lcg_chk_pkg::*;
#(
  parameter logic [31:0] MULT = LCG_MULT,
  parameter logic [31:0] INC  = LCG_INC
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = lcg_next(x, MULT, INC);

endmodule

// File: rtl/lcg_stream_checker.sv
// Checks an incoming word stream against a regenerated LCG sequence.
// Optional MISR signature when LCG_CHK_MISR_EN is defined.
//
// state  | meaning
// IDLE   | no reference yet; the first accepted word seeds the sequence
// HUNT   | follow the incoming data, count consecutive matches toward lock
// LOCKED | free-run the reference, count mismatches, drop out on a burst
module lcg_stream_checker
  import lcg_chk_pkg::*;
#(
  parameter logic [31:0] MULT        = LCG_MULT,
  parameter logic [31:0] INC         = LCG_INC,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned UNLOCK_ERRS = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [31:0]      signature
);

  localparam logic [7:0]       LOCK_TC   = 8'(LOCK_CNT);
  localparam logic [7:0]       UNLOCK_TC = 8'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  chk_state_t  state, state_n;
  logic [31:0] expected, expected_n;
  logic [7:0]  match_run, match_run_n;
  logic [7:0]  err_run, err_run_n;
  logic        err_hit;
  logic        accept;
  logic [31:0] step_a_in, data_next, exp_next;

  assign in_ready = !rst && !seed_load;
  assign accept   = in_valid && in_ready;
  assign locked   = (state == LOCKED);

  // The data-side stepper is shared with the seed path; seed_load blocks accepts.
  assign step_a_in = seed_load ? seed_in : in_data;

  lcg_step #(.MULT(MULT), .INC(INC)) u_step_data (.x(step_a_in), .y(data_next));
  lcg_step #(.MULT(MULT), .INC(INC)) u_step_exp  (.x(expected),  .y(exp_next));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      expected  <= '0;
      match_run <= '0;
      err_run   <= '0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_run <= match_run_n;
      err_run   <= err_run_n;
    end
  end

  always_comb begin
    state_n     = state;
    expected_n  = expected;
    match_run_n = match_run;
    err_run_n   = err_run;
    err_hit     = 1'b0;
    if (seed_load) begin
      state_n     = LOCKED;
      expected_n  = data_next;
      match_run_n = '0;
      err_run_n   = '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          state_n     = HUNT;
          expected_n  = data_next;
          match_run_n = '0;
        end
        HUNT: begin
          expected_n = data_next;
          if (in_data == expected) begin
            if (match_run + 8'd1 == LOCK_TC) begin
              state_n     = LOCKED;
              match_run_n = '0;
              err_run_n   = '0;
            end else begin
              match_run_n = match_run + 8'd1;
            end
          end else begin
            match_run_n = '0;
          end
        end
        LOCKED: begin
          if (in_data == expected) begin
            err_run_n  = '0;
            expected_n = exp_next;
          end else begin
            err_hit = 1'b1;
            if (err_run + 8'd1 == UNLOCK_TC) begin
              state_n     = HUNT;
              match_run_n = '0;
              err_run_n   = '0;
              expected_n  = data_next;
            end else begin
              err_run_n  = err_run + 8'd1;
              expected_n = exp_next;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse  <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      err_pulse <= err_hit;
      if (accept && (word_count != '1)) word_count <= word_count + CNT_ONE;
      if (err_hit && (err_count != '1)) err_count <= err_count + CNT_ONE;
    end
  end

`ifdef LCG_CHK_MISR_EN
  logic [31:0] sig_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_INIT;
    end else if (accept) begin
      sig_q <= {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ in_data;
    end
  end
  assign signature = sig_q;
`else
  assign signature = 32'h0;
`endif

endmodule
